// File: rtl/ddr_ioctl_upload_adaptor_pkg.sv
// Shared DDR/ioctl definitions for the upload (read) and download (write) adaptors.
package ddr_ioctl_upload_adaptor_pkg;
  localparam int DDR_DW   = 64;
  localparam int DDR_BEW  = DDR_DW / 8;
  localparam int IOCTL_AW = 25;

  typedef logic [7:0] ddr_burstcnt_t;

  localparam logic [7:0] IOCTL_INDEX_ROM   = 8'd0;
  localparam logic [7:0] UPLOAD_INDEX_SAVE = 8'd3;

  // Little-endian lane select: byte k of a beat lives in bits [8k+7:8k].
  function automatic logic [7:0] byte_of_beat(input logic [DDR_DW-1:0] beat, input logic [2:0] k);
    byte_of_beat = beat[{k, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/ddr_ioctl_upload_adaptor_if.sv
// hps_io upload port plus one ddr_mux leg, bundled for the upload adaptor.
interface ddr_ioctl_upload_adaptor_if;
  import ddr_ioctl_upload_adaptor_pkg::*;

  // ioctl_rd is a one-cycle strobe that may only be issued while ioctl_wait is 0; ioctl_din is
  // valid once ioctl_wait is 0 after it. ddr_read is held with a stable ddr_addr until a cycle
  // with ddr_busy low, which accepts it; beats then arrive on ddr_read_complete.
  logic                ioctl_upload;
  logic [7:0]          ioctl_index;
  logic                ioctl_rd;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_din;
  logic                ioctl_wait;
  logic                ioctl_upload_req;
  logic                save_done;
  logic                ddr_acquire;
  logic [31:0]         ddr_addr;
  logic                ddr_read;
  ddr_burstcnt_t       ddr_burstcnt;
  logic [DDR_DW-1:0]   ddr_rdata;
  logic                ddr_read_complete;
  logic                ddr_busy;
  logic                ddr_write;
  logic [DDR_DW-1:0]   ddr_wdata;
  logic [DDR_BEW-1:0]  ddr_byteenable;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, save_done,
           ddr_rdata, ddr_read_complete, ddr_busy,
    output ioctl_din, ioctl_wait, ioctl_upload_req,
           ddr_acquire, ddr_addr, ddr_read, ddr_burstcnt, ddr_write, ddr_wdata, ddr_byteenable
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, save_done,
           ddr_rdata, ddr_read_complete, ddr_busy,
    input  ioctl_din, ioctl_wait, ioctl_upload_req,
           ddr_acquire, ddr_addr, ddr_read, ddr_burstcnt, ddr_write, ddr_wdata, ddr_byteenable
  );
endinterface

// File: rtl/ddr_ioctl_upload_adaptor.sv
// Serves hps_io upload reads from DDR through a one-line burst buffer and requests an upload
// whenever the save-state writer finishes.
module ddr_ioctl_upload_adaptor
  import ddr_ioctl_upload_adaptor_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3E00_0000,
  parameter int          BURST_LEN    = 4,
  parameter logic [7:0]  UPLOAD_INDEX = UPLOAD_INDEX_SAVE
) (
  input  logic                         clk,
  input  logic                         reset_n,
  ddr_ioctl_upload_adaptor_if.slave    bus,
  output logic [1:0]                   o_dbg_state
);
  localparam int LINE_BYTES = BURST_LEN * 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int TAG_W      = IOCTL_AW - OFF_W;
  localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, RECV} state_t;

  state_t              r_state, w_next;
  logic                r_valid;
  logic [TAG_W-1:0]    r_tag;
  logic [DDR_DW-1:0]   r_line [BURST_LEN];
  logic [IOCTL_AW-1:0] r_addr;
  logic [CNT_W-1:0]    r_beat;
  logic [7:0]          r_din;
  logic                r_wait;
  logic                r_upload_d;
  logic                r_pending;
  logic                r_upload_req;
  logic                r_stale;
  logic                r_abort;

  logic                w_active, w_rise, w_fall, w_inval, w_hit;
  logic                w_rd_hit, w_rd_miss, w_beat, w_last;
  logic [CNT_W-1:0]    w_sel_in, w_sel_r;
  logic [DDR_DW-1:0]   w_fill_beat;
  logic [7:0]          w_hit_byte, w_fill_byte;
  logic [31:0]         w_line_addr;

  assign w_active = bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
  assign w_rise   = bus.ioctl_upload && !r_upload_d;
  assign w_fall   = !bus.ioctl_upload && r_upload_d;
  assign w_inval  = w_rise || bus.save_done;
  assign w_hit    = r_valid && !w_inval && (bus.ioctl_addr[IOCTL_AW-1:OFF_W] == r_tag);

  assign w_sel_in    = CNT_W'(bus.ioctl_addr[OFF_W-1:0] >> 3);
  assign w_sel_r     = CNT_W'(r_addr[OFF_W-1:0] >> 3);
  assign w_hit_byte  = byte_of_beat(r_line[w_sel_in], bus.ioctl_addr[2:0]);
  // Beats arrive in order, so only the last beat can still be on the bus rather than in r_line.
  assign w_fill_beat = (w_sel_r == CNT_W'(BURST_LEN - 1)) ? bus.ddr_rdata : r_line[w_sel_r];
  assign w_fill_byte = byte_of_beat(w_fill_beat, r_addr[2:0]);
  assign w_line_addr = BASE_ADDR + {7'd0, r_addr[IOCTL_AW-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    w_next    = r_state;
    w_rd_hit  = 1'b0;
    w_rd_miss = 1'b0;
    w_beat    = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_active && bus.ioctl_rd) begin
          if (w_hit) begin
            w_rd_hit = 1'b1;
          end else begin
            w_rd_miss = 1'b1;
            w_next    = FETCH;
          end
        end
      end
      FETCH: begin
        if (!bus.ddr_busy) w_next = RECV;
      end
      RECV: begin
        if (bus.ddr_read_complete) begin
          w_beat = 1'b1;
          if (r_beat == CNT_W'(BURST_LEN - 1)) begin
            w_last = 1'b1;
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid      <= 1'b0;
      r_tag        <= '0;
      r_addr       <= '0;
      r_beat       <= '0;
      r_din        <= '0;
      r_wait       <= 1'b0;
      r_upload_d   <= 1'b0;
      r_pending    <= 1'b0;
      r_upload_req <= 1'b0;
      r_stale      <= 1'b0;
      r_abort      <= 1'b0;
      for (int i = 0; i < BURST_LEN; i++) r_line[i] <= '0;
    end else begin
      r_upload_d   <= bus.ioctl_upload;
      r_upload_req <= 1'b0;
      // A save finishing mid-upload is remembered and announced once the upload ends.
      if (!bus.ioctl_upload && (bus.save_done || (w_fall && r_pending))) begin
        r_upload_req <= 1'b1;
        r_pending    <= 1'b0;
      end else if (bus.save_done) begin
        r_pending <= 1'b1;
      end

      if (w_inval)  r_valid <= 1'b0;
      if (w_rd_hit) r_din   <= w_hit_byte;
      if (w_rd_miss) begin
        r_wait  <= 1'b1;
        r_addr  <= bus.ioctl_addr;
        r_beat  <= '0;
        r_stale <= 1'b0;
        r_abort <= 1'b0;
      end
      if (r_state != IDLE) begin
        if (w_inval)           r_stale <= 1'b1;
        if (!bus.ioctl_upload) r_abort <= 1'b1;
      end
      if (w_beat) begin
        r_line[r_beat] <= bus.ddr_rdata;
        r_beat         <= r_beat + 1'b1;
      end
      if (w_last) begin
        r_wait <= 1'b0;
        if (!r_abort && bus.ioctl_upload) begin
          r_din <= w_fill_byte;
          if (!r_stale && !w_inval) begin
            r_valid <= 1'b1;
            r_tag   <= r_addr[IOCTL_AW-1:OFF_W];
          end
        end
      end
    end
  end

  assign bus.ioctl_din        = r_din;
  assign bus.ioctl_wait       = r_wait;
  assign bus.ioctl_upload_req = r_upload_req;
  assign bus.ddr_acquire      = (r_state != IDLE);
  assign bus.ddr_read         = (r_state == FETCH);
  assign bus.ddr_addr         = (r_state == IDLE) ? 32'd0 : w_line_addr;
  assign bus.ddr_burstcnt     = ddr_burstcnt_t'(BURST_LEN);
  assign bus.ddr_write        = 1'b0;
  assign bus.ddr_wdata        = '0;
  assign bus.ddr_byteenable   = '1;
  assign o_dbg_state          = r_state;
endmodule

// File: tb/tb_ddr_ioctl_upload_adaptor.sv
// Directed bench for ddr_ioctl_upload_adaptor: table of upload reads plus hand-written sequences.
module tb_ddr_ioctl_upload_adaptor;
  localparam logic [31:0] BASE = 32'h3E00_0000;
  localparam int          BL   = 4;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;

  ddr_ioctl_upload_adaptor_if bus();

  ddr_ioctl_upload_adaptor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int gen = 0;
  int fetch_count = 0;
  int burst_beats = 0;
  int read_cycles = 0;
  int last_read_cycles = 0;
  int stall_cnt = 0;
  int req_pulses = 0;
  bit addr_unstable = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] first_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ddr_beat(input logic [31:0] a);
    logic [31:0] off;
    logic [63:0] b;
    off = a - BASE;
    for (int k = 0; k < 8; k++) b[8*k +: 8] = 8'(off + 32'(k)) + 8'(gen * 64);
    return b;
  endfunction

  // DDR leg model: optional busy stall, 2-cycle latency, then back-to-back beats.
  initial begin
    int beats_left;
    int delay;
    logic [31:0] beat_addr;
    beats_left = 0;
    delay = 0;
    beat_addr = '0;
    bus.ddr_busy = 1'b0;
    bus.ddr_read_complete = 1'b0;
    bus.ddr_rdata = '0;
    forever begin
      @(negedge clk);
      bus.ddr_read_complete = 1'b0;
      if (!reset_n) begin
        beats_left = 0;
        read_cycles = 0;
        bus.ddr_busy = 1'b0;
      end else begin
        if (beats_left > 0) begin
          if (delay > 0) begin
            delay--;
          end else begin
            bus.ddr_rdata = ddr_beat(beat_addr);
            bus.ddr_read_complete = 1'b1;
            beat_addr += 8;
            beats_left--;
            burst_beats++;
            chk("acquire_mid_burst", bus.ddr_acquire, 1);
          end
        end
        if (bus.ddr_read) begin
          if (read_cycles == 0) first_addr = bus.ddr_addr;
          else if (bus.ddr_addr !== first_addr) addr_unstable = 1;
          read_cycles++;
          if (stall_cnt > 0) begin
            bus.ddr_busy = 1'b1;
            stall_cnt--;
          end else begin
            bus.ddr_busy = 1'b0;
            fetch_count++;
            last_addr = bus.ddr_addr;
            last_read_cycles = read_cycles;
            read_cycles = 0;
            chk("burstcnt", bus.ddr_burstcnt, BL);
            beats_left = BL;
            burst_beats = 0;
            beat_addr = bus.ddr_addr;
            delay = 2;
          end
        end else begin
          bus.ddr_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (bus.ioctl_upload_req) req_pulses++;

  always @(posedge clk)
    if (reset_n) assert (!(bus.ioctl_rd && bus.ioctl_wait)) else $error("ioctl_rd issued while ioctl_wait high");

  task automatic do_rd(input logic [24:0] a, output logic [7:0] d, output bit waited);
    int n;
    @(negedge clk);
    bus.ioctl_addr = a;
    bus.ioctl_rd = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    waited = bus.ioctl_wait;
    n = 0;
    while (bus.ioctl_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.ioctl_wait) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: addr %0h still waiting after %0d cycles", a, n);
    end
    d = bus.ioctl_din;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_din"}, bus.ioctl_din, 0);
    chk({tag, "_wait"}, bus.ioctl_wait, 0);
    chk({tag, "_acquire"}, bus.ddr_acquire, 0);
    chk({tag, "_read"}, bus.ddr_read, 0);
    chk({tag, "_addr"}, bus.ddr_addr, 0);
    chk({tag, "_upload_req"}, bus.ioctl_upload_req, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          fetches;
    logic [31:0] faddr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] d;
    bit waited;
    int fc0;
    int p0;
    bit any_acq;
    bit any_wait;

    vecs[0] = '{25'h000000, 8'h00, 1, 32'h3E00_0000};
    vecs[1] = '{25'h000005, 8'h05, 0, 32'h0};
    vecs[2] = '{25'h00001F, 8'h1F, 0, 32'h0};
    vecs[3] = '{25'h000020, 8'h20, 1, 32'h3E00_0020};
    vecs[4] = '{25'h000021, 8'h21, 0, 32'h0};
    vecs[5] = '{25'h000000, 8'h00, 1, 32'h3E00_0000};
    vecs[6] = '{25'h0001FF, 8'hFF, 1, 32'h3E00_01E0};
    vecs[7] = '{25'h123456, 8'h56, 1, 32'h3E12_3440};

    reset_n = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0;
    bus.save_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_write", bus.ddr_write, 0);
    chk("reset_byteenable", bus.ddr_byteenable, 8'hFF);
    #1 reset_n = 1'b1;

    // Table: cold read, hits in the line, line crossing, evictions, last-beat bypass.
    @(negedge clk);
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index = 8'd3;
    for (int i = 0; i < 8; i++) begin
      fc0 = fetch_count;
      do_rd(vecs[i].addr, d, waited);
      chk($sformatf("v%0d_din", i), d, vecs[i].din);
      chk($sformatf("v%0d_fetches", i), fetch_count - fc0, vecs[i].fetches);
      chk($sformatf("v%0d_waited", i), waited, vecs[i].fetches != 0);
      if (vecs[i].fetches != 0) begin
        chk($sformatf("v%0d_ddr_addr", i), last_addr, vecs[i].faddr);
        chk($sformatf("v%0d_read_cycles", i), last_read_cycles, 1);
      end
    end

    // Busy stall: read held for 10 busy cycles, accepted on the 11th.
    addr_unstable = 0;
    stall_cnt = 10;
    fc0 = fetch_count;
    do_rd(25'h000047, d, waited);
    chk("busy_din", d, 8'h47);
    chk("busy_fetches", fetch_count - fc0, 1);
    chk("busy_read_cycles", last_read_cycles, 11);
    chk("busy_addr_stable", addr_unstable, 0);
    chk("busy_ddr_addr", last_addr, 32'h3E00_0040);

    // Wrong index: reads are ignored entirely.
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    repeat (3) @(negedge clk);
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index = 8'd1;
    fc0 = fetch_count;
    @(negedge clk);
    bus.ioctl_addr = 25'h000100;
    bus.ioctl_rd = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    any_acq = 0;
    any_wait = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ddr_acquire) any_acq = 1;
      if (bus.ioctl_wait) any_wait = 1;
      @(negedge clk);
    end
    chk("wrong_idx_acquire", any_acq, 0);
    chk("wrong_idx_wait", any_wait, 0);
    chk("wrong_idx_fetches", fetch_count - fc0, 0);
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index = 8'd3;
    repeat (3) @(negedge clk);

    // Invalidate: save_done during an upload, deferred upload_req, refetch of new data.
    bus.ioctl_upload = 1'b1;
    do_rd(25'h0, d, waited);
    chk("inv_first_din", d, 8'h00);
    fc0 = fetch_count;
    do_rd(25'h0, d, waited);
    chk("inv_hit_fetches", fetch_count - fc0, 0);
    p0 = req_pulses;
    @(negedge clk);
    bus.save_done = 1'b1;
    @(negedge clk);
    bus.save_done = 1'b0;
    gen = 1;
    repeat (3) @(negedge clk);
    chk("inv_no_req_during_upload", req_pulses - p0, 0);
    fc0 = fetch_count;
    do_rd(25'h0, d, waited);
    chk("inv_refetch_fetches", fetch_count - fc0, 1);
    chk("inv_refetch_din", d, 8'h40);
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    chk("inv_req_pulse", bus.ioctl_upload_req, 1);
    @(negedge clk);
    chk("inv_req_drop", bus.ioctl_upload_req, 0);
    @(negedge clk);
    chk("inv_req_count", req_pulses - p0, 1);
    bus.ioctl_upload = 1'b1;
    fc0 = fetch_count;
    do_rd(25'h0, d, waited);
    chk("inv_new_upload_fetches", fetch_count - fc0, 1);
    chk("inv_new_upload_din", d, 8'h40);

    // Reset after two beats of a burst, then a clean refetch.
    fc0 = fetch_count;
    @(negedge clk);
    bus.ioctl_addr = 25'h000100;
    bus.ioctl_rd = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (fetch_count == fc0 + 1 && burst_beats == 2) break;
      @(negedge clk);
    end
    chk("rst_reached_beat2", burst_beats, 2);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("midburst_reset");
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    fc0 = fetch_count;
    do_rd(25'h000100, d, waited);
    chk("rst_refetch_fetches", fetch_count - fc0, 1);
    chk("rst_refetch_addr", last_addr, 32'h3E00_0100);
    chk("rst_refetch_din", d, 8'h40);

    // save_done with no upload in progress: pulse on the very next cycle.
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    repeat (3) @(negedge clk);
    bus.save_done = 1'b1;
    @(negedge clk);
    bus.save_done = 1'b0;
    chk("idle_save_req_pulse", bus.ioctl_upload_req, 1);
    @(negedge clk);
    chk("idle_save_req_drop", bus.ioctl_upload_req, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
